// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Data-memory responder: word RAM below two MMIO words (io_out port, cycle counter).
// A sequential clear engine zero-fills the RAM after every reset.
//
// state | meaning
// CLEAR | zero-fill engine writes RAM[ptr] each cycle; processor requests ignored, q = 0
// READY | processor reads/writes serviced with 1-cycle latency, read-first on writes
module dmem_responder #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] io_out
);

  localparam int RAM_DEPTH = (1 << ADDR_WIDTH) - 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_RAM = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IO_ADDR  = ADDR_WIDTH'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(RAM_DEPTH + 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0]   cycle_cnt;
  logic [DATA_WIDTH-1:0]   ram [RAM_DEPTH];

  logic                    sel_io, sel_cnt, sel_ram;
  logic                    ram_we, io_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   rd_word, q_nxt;

  assign sel_io  = (address == IO_ADDR);
  assign sel_cnt = (address == CNT_ADDR);
  assign sel_ram = !sel_io && !sel_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Old contents of the addressed word; the counter reads its pre-increment value.
  always_comb begin
    if (sel_io)
      rd_word = io_out;
    else if (sel_cnt)
      rd_word = cycle_cnt;
    else
      rd_word = ram[address];
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = address;
    ram_wdata = data;
    io_we     = 1'b0;
    q_nxt     = '0;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = ptr;
        ram_wdata = '0;
        ptr_nxt   = ptr + 1'b1;
        if (ptr == LAST_RAM)
          state_nxt = READY;
      end
      READY: begin
        ram_we = wren && sel_ram;
        io_we  = wren && sel_io;
        q_nxt  = rd_word;
      end
    endcase
  end

  // A request presented together with reset is dropped.
  always_ff @(posedge clock) begin
    if (ram_we && !reset)
      ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q         <= '0;
      io_out    <= '0;
      cycle_cnt <= '0;
    end else begin
      q         <= q_nxt;
      cycle_cnt <= cycle_cnt + 1'b1;
      if (io_we)
        io_out <= data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Directed bench for dmem_responder: expected q values go through a scoreboard queue,
// covering the post-reset clear, RAM/MMIO access, mid-clear reset and the no-clear variant.
module tb_dmem_responder;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CLEAR_CYCLES = 4094;

  logic          clock = 1'b0;
  logic          reset, nc_reset;
  logic [AW-1:0] address, nc_address;
  logic [DW-1:0] data, nc_data;
  logic          wren, nc_wren;
  logic [DW-1:0] q, nc_q, io_out, nc_io_out;
  logic          busy, nc_busy;
  logic [DW-1:0] model_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren),
    .q(q), .busy(busy), .io_out(io_out)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clock(clock), .reset(nc_reset), .address(nc_address), .data(nc_data), .wren(nc_wren),
    .q(nc_q), .busy(nc_busy), .io_out(nc_io_out)
  );

  // Reference cycle counter: value held before each edge's increment.
  always @(posedge clock) begin
    if (reset) model_cnt <= '0;
    else       model_cnt <= model_cnt + 1'b1;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive at negedge, push expectation, compare q just after the edge.
  task automatic req(input bit sel_nc, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic we, input bit chk, input logic [DW-1:0] exp, input string tag);
    sb_t e;
    @(negedge clock);
    if (sel_nc) begin
      nc_address = a; nc_data = d; nc_wren = we;
    end else begin
      address = a; data = d; wren = we;
    end
    if (chk) begin
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (sel_nc) nc_wren = 1'b0;
    else        wren = 1'b0;
    if (chk) begin
      e = sb.pop_front();
      check(e.tag, sel_nc ? nc_q : q, e.exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] cnt_exp;
    reset = 1'b1; nc_reset = 1'b1;
    address = '0; data = '0; wren = 1'b0;
    nc_address = '0; nc_data = '0; nc_wren = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_q", q, '0);
    check("rst_io_out", io_out, '0);
    check("rst_busy", 32'(busy), 32'd1);
    check("nc_rst_busy", 32'(nc_busy), 32'd0);
    check("nc_rst_q", nc_q, '0);
    check("nc_rst_io_out", nc_io_out, '0);

    // No-clear variant: serviced from the very first edge after reset.
    nc_reset = 1'b0;
    req(1'b1, 12'h001, 32'h1234_5678, 1'b1, 1'b0, '0, "nc_write");
    check("nc_busy_after_write", 32'(nc_busy), 32'd0);
    req(1'b1, 12'h001, '0, 1'b0, 1'b1, 32'h1234_5678, "nc_read_001");
    req(1'b1, 12'hFFE, 32'h0000_003C, 1'b1, 1'b1, 32'h0, "nc_io_write_q");
    check("nc_io_out", nc_io_out, 32'h0000_003C);

    // Full clear: busy through the 4094th edge, low after it.
    reset = 1'b0;
    for (int i = 1; i <= CLEAR_CYCLES; i++) begin
      req(1'b0, 12'h000, '0, 1'b0, 1'b1, '0, "clear_q");
      check("clear_busy", 32'(busy), (i < CLEAR_CYCLES) ? 32'd1 : 32'd0);
    end

    req(1'b0, 12'h000, '0, 1'b0, 1'b1, 32'h0, "read_000");
    req(1'b0, 12'h7FF, '0, 1'b0, 1'b1, 32'h0, "read_7ff");
    req(1'b0, 12'hFFD, '0, 1'b0, 1'b1, 32'h0, "read_ffd");
    check("ready_busy", 32'(busy), 32'd0);

    req(1'b0, 12'h010, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, "write_010_q");
    req(1'b0, 12'h010, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, "read_010");

    req(1'b0, 12'h020, 32'h1234_5678, 1'b1, 1'b1, 32'h0, "write1_020_q");
    req(1'b0, 12'h020, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h1234_5678, "write2_020_q");
    req(1'b0, 12'h020, '0, 1'b0, 1'b1, 32'hCAFE_F00D, "read_020");
    req(1'b0, 12'h010, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, "reread_010");

    req(1'b0, 12'hFFE, 32'h0000_00A5, 1'b1, 1'b1, 32'h0, "io_write_q");
    check("io_out_a5", io_out, 32'h0000_00A5);
    req(1'b0, 12'hFFE, '0, 1'b0, 1'b1, 32'h0000_00A5, "io_read");

    cnt_exp = model_cnt;
    req(1'b0, 12'hFFF, '0, 1'b0, 1'b1, cnt_exp, "cnt_read1");
    req(1'b0, 12'hFFF, 32'h1, 1'b1, 1'b1, model_cnt, "cnt_write_q");
    req(1'b0, 12'hFFF, '0, 1'b0, 1'b1, cnt_exp + 32'd2, "cnt_read2");
    check("io_out_kept", io_out, 32'h0000_00A5);

    // Reset in READY drops the concurrent io write.
    @(negedge clock);
    reset = 1'b1; address = 12'hFFE; data = 32'h0000_0077; wren = 1'b1;
    @(posedge clock);
    #1;
    wren = 1'b0;
    check("rst_ready_io_out", io_out, 32'h0);
    check("rst_ready_q", q, 32'h0);
    check("rst_ready_busy", 32'(busy), 32'd1);
    reset = 1'b0;

    for (int i = 1; i <= 2000; i++)
      req(1'b0, 12'h000, '0, 1'b0, 1'b1, '0, "clear2_q");
    check("midclear_busy_before", 32'(busy), 32'd1);

    // Mid-clear reset restarts the clear from zero.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midclear_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    for (int i = 1; i <= CLEAR_CYCLES; i++) begin
      if (i == 10)
        req(1'b0, 12'h005, 32'h0000_0055, 1'b1, 1'b1, '0, "clear3_write_005_q");
      else if (i == 20)
        req(1'b0, 12'hFFE, 32'h0000_0099, 1'b1, 1'b1, '0, "clear3_write_io_q");
      else
        req(1'b0, 12'h000, '0, 1'b0, 1'b1, '0, "clear3_q");
      check("restart_busy", 32'(busy), (i < CLEAR_CYCLES) ? 32'd1 : 32'd0);
    end

    req(1'b0, 12'h005, '0, 1'b0, 1'b1, 32'h0, "read_005_dropped");
    req(1'b0, 12'h010, '0, 1'b0, 1'b1, 32'h0, "read_010_recleared");
    check("io_out_not_written_in_clear", io_out, 32'h0);
    req(1'b0, 12'hFFF, '0, 1'b0, 1'b1, model_cnt, "cnt_after_reset");
    req(1'b0, 12'hFFD, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0, "write_ffd_q");
    req(1'b0, 12'hFFD, '0, 1'b0, 1'b1, 32'h5555_AAAA, "read_ffd_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Synchronous data-memory responder that serves the processor's data-memory port (address, write data, write enable, read data). It backs the lower address space with a word RAM and decodes the top two word addresses as memory-mapped I/O: an output port register and a free-running cycle counter. After every reset it zero-fills the RAM with a sequential clear engine, so the processor always starts from known data.

## Interface
- ADDR_WIDTH, 12, word-address width; the RAM holds 2^ADDR_WIDTH − 2 words (4094).
- DATA_WIDTH, 32, word width.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill after reset; 0 = skip straight to READY.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- address  input  ADDR_WIDTH  word address from the processor.
- data  input  DATA_WIDTH  write data.
- wren  input  1  write enable; 1 = write, 0 = read.
- q  output  DATA_WIDTH  registered read data.
- busy  output  1  high while the clear engine runs.
- io_out  output  DATA_WIDTH  output port register (MMIO 0xFFE).

## Operation
- Address map:
  - 0x000–0xFFD: RAM.
  - 0xFFE: io_out, read/write.
  - 0xFFF: cycle counter, read-only; writes are ignored.
- The FSM has two states, CLEAR and READY.
  - Reset sends the FSM to CLEAR, or to READY when CLEAR_ON_RESET = 0.
  - Reset also clears the clear pointer, q, io_out and the cycle counter to 0.
- CLEAR state:
  - Each cycle writes 0 to RAM[ptr], then increments ptr.
  - After the edge that writes ptr = 0xFFD, the FSM moves to READY.
  - busy = 1 exactly while the FSM is in CLEAR.
  - Processor requests are ignored: no RAM or io_out write occurs, and q is driven to 0.
- READY state:
  - Read (wren = 0): q <= the addressed word (RAM, io_out, or the counter).
  - Write (wren = 1) to RAM or io_out: the target is updated with data. q <= the old contents of the addressed location (read-first).
  - Write to 0xFFF: no state change; q <= the counter value.
- Cycle counter:
  - Increments by 1 every cycle in which reset is low, in both states.
  - Wraps from 0xFFFFFFFF to 0.
  - A read returns the value held before that edge's increment.
- Reset asserted mid-clear restarts the clear from ptr = 0. Reset asserted in READY discards any request in that cycle.
- Address bits above ADDR_WIDTH do not exist; there are no out-of-range cases.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N, and q is valid after edge N and holds until edge N+1.
- Write latency: the write lands at edge N and is visible to a read sampled at edge N+1.
- Read-during-write to the same address in one cycle returns the old data.
- Clear duration is 4094 cycles.
  - The first clear write occurs at the first edge with reset low.
  - busy falls after the 4094th such edge.
  - The request sampled at edge 4095 is the first one serviced.
- Reset values: q = 0, io_out = 0, counter = 0, busy = 1 (0 if CLEAR_ON_RESET = 0).
- There is no backpressure or ready signal. The processor tolerates busy by design (the skeleton holds the processor off during the clear).

## Test plan
- Reset, then release for 4094 cycles: busy = 1 through the 4094th edge and 0 after it. Reading 0x000, 0x7FF and 0xFFD then returns 0 one cycle after each address.
- After the clear, write 0xDEADBEEF to 0x010, then read 0x010: q = 0xDEADBEEF on the cycle after the read; q on the write cycle = 0.
- Write 0x12345678 to 0x020, then write 0xCAFEF00D to 0x020, reading back-to-back: second write's q = 0x12345678, following read's q = 0xCAFEF00D.
- Write 0x000000A5 to 0xFFE: io_out = 0x000000A5 after the edge. A read of 0xFFE returns 0xA5. A write of 0x1 to 0xFFF leaves the counter unaffected, and the next read of 0xFFF returns a value 2 greater than the previous read taken 2 cycles earlier.
- Mid-clear reset: assert reset at clear cycle 2000 for 1 cycle. busy stays high for a further 4094 cycles, and a write to 0x005 issued during busy is dropped (a read after the clear returns 0).
- With CLEAR_ON_RESET = 0: busy = 0 from reset, and a write/read to 0x001 on the first cycles after reset succeeds with 1-cycle latency.
